// File: rtl/arf_multiport.sv
// Architectural register file with configurable read/retire ports, optional
// retire-to-read bypass and a valid/ready dump stream of every register.
module arf_multiport #(
  parameter int NUM_REG      = 32,
  parameter int NUM_REG_LOG2 = $clog2(NUM_REG),
  parameter int REG_SIZE     = 32,
  parameter int NUM_READ     = 2,
  parameter int NUM_RETIRE   = 2,
  parameter int BYPASS       = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_READ-1:0][NUM_REG_LOG2-1:0]    rd_addr,
  output logic [NUM_READ-1:0][REG_SIZE-1:0]        rd_data,
  input  logic [NUM_RETIRE-1:0][NUM_REG_LOG2-1:0]  retire_reg,
  input  logic [NUM_RETIRE-1:0][REG_SIZE-1:0]      retire_reg_data,
  input  logic [NUM_RETIRE-1:0]                    retire_valid,
  input  logic                                     dump_req,
  input  logic                                     dump_ready,
  output logic                                     dump_valid,
  output logic [NUM_REG_LOG2-1:0]                  dump_idx,
  output logic [REG_SIZE-1:0]                      dump_data,
  output logic                                     dump_last,
  output logic                                     dump_busy
);

  typedef enum logic {IDLE, DUMP} dump_state_t;

  // Handshake: a dump beat transfers on a rising edge where dump_valid and
  // dump_ready are both high; dump_idx/dump_data hold while dump_ready is low.

  dump_state_t state, state_next;
  logic [NUM_REG_LOG2-1:0] idx_next, idx_inc;
  logic [REG_SIZE-1:0]     data_next;

  logic [REG_SIZE-1:0] arf      [NUM_REG];
  logic [REG_SIZE-1:0] arf_next [NUM_REG];

  // Later slots overwrite earlier ones, so the highest-numbered valid slot wins.
  always_comb begin
    for (int i = 0; i < NUM_REG; i++) begin
      arf_next[i] = arf[i];
      for (int k = 0; k < NUM_RETIRE; k++) begin
        if (retire_valid[k] && (i != 0) && (retire_reg[k] == NUM_REG_LOG2'(i))) begin
          arf_next[i] = retire_reg_data[k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REG; i++) begin
        arf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REG; i++) begin
        arf[i] <= arf_next[i];
      end
    end
  end

  // Index 0 never gets a write in arf_next, so bypass cannot touch it.
  always_comb begin
    for (int p = 0; p < NUM_READ; p++) begin
      if (BYPASS != 0) begin
        rd_data[p] = arf_next[rd_addr[p]];
      end else begin
        rd_data[p] = arf[rd_addr[p]];
      end
    end
  end

  assign idx_inc    = dump_idx + NUM_REG_LOG2'(1);
  assign dump_valid = (state == DUMP);
  assign dump_busy  = (state == DUMP);
  assign dump_last  = (state == DUMP) && (dump_idx == NUM_REG_LOG2'(NUM_REG - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dump_idx  <= '0;
      dump_data <= '0;
    end else begin
      state     <= state_next;
      dump_idx  <= idx_next;
      dump_data <= data_next;
    end
  end

  // Loaded beats take the post-write value so same-edge retires are included.
  always_comb begin
    state_next = state;
    idx_next   = dump_idx;
    data_next  = dump_data;
    case (state)
      IDLE: begin
        if (dump_req) begin
          state_next = DUMP;
          idx_next   = '0;
          data_next  = arf_next[0];
        end
      end
      DUMP: begin
        if (dump_ready) begin
          if (dump_last) begin
            state_next = IDLE;
            idx_next   = '0;
            data_next  = '0;
          end else begin
            idx_next  = idx_inc;
            data_next = arf_next[idx_inc];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_arf_multiport.sv
// Directed bench for arf_multiport: one bypass and one non-bypass instance
// share stimulus; table vectors for reads/writes, sequences for dump cases.
module tb_arf_multiport;
  localparam int NR  = 32;
  localparam int LG  = 5;
  localparam int W   = 32;
  localparam int NRD = 2;
  localparam int NRT = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NRD-1:0][LG-1:0] rd_addr;
  logic [NRD-1:0][W-1:0]  rd_data_b, rd_data_n;
  logic [NRT-1:0][LG-1:0] retire_reg;
  logic [NRT-1:0][W-1:0]  retire_reg_data;
  logic [NRT-1:0]         retire_valid;
  logic dump_req, dump_ready;
  logic dv_b, dl_b, db_b, dv_n, dl_n, db_n;
  logic [LG-1:0] di_b, di_n;
  logic [W-1:0]  dd_b, dd_n;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [1:0]    rv;
    logic [LG-1:0] r0, r1;
    logic [W-1:0]  d0, d1;
    logic [LG-1:0] a0, a1;
    logic [W-1:0]  eb0, eb1, en0, en1;
  } vec_t;
  vec_t vecs[10];

  arf_multiport #(.NUM_REG(NR), .REG_SIZE(W), .NUM_READ(NRD), .NUM_RETIRE(NRT), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .retire_reg(retire_reg), .retire_reg_data(retire_reg_data), .retire_valid(retire_valid),
    .dump_req(dump_req), .dump_ready(dump_ready), .dump_valid(dv_b), .dump_idx(di_b),
    .dump_data(dd_b), .dump_last(dl_b), .dump_busy(db_b)
  );

  arf_multiport #(.NUM_REG(NR), .REG_SIZE(W), .NUM_READ(NRD), .NUM_RETIRE(NRT), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .retire_reg(retire_reg), .retire_reg_data(retire_reg_data), .retire_valid(retire_valid),
    .dump_req(dump_req), .dump_ready(dump_ready), .dump_valid(dv_n), .dump_idx(di_n),
    .dump_data(dd_n), .dump_last(dl_n), .dump_busy(db_n)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire_clear();
    retire_valid    = '0;
    retire_reg      = '0;
    retire_reg_data = '0;
  endtask

  task automatic preload();
    for (int i = 1; i < NR; i++) begin
      retire_valid       = 2'b01;
      retire_reg[0]      = LG'(i);
      retire_reg_data[0] = W'(i * 256);
      tick();
    end
    retire_clear();
  endtask

  function automatic vec_t mk(input logic [1:0] rv, input logic [LG-1:0] r0, input logic [W-1:0] d0,
                              input logic [LG-1:0] r1, input logic [W-1:0] d1,
                              input logic [LG-1:0] a0, input logic [LG-1:0] a1,
                              input logic [W-1:0] eb0, input logic [W-1:0] eb1,
                              input logic [W-1:0] en0, input logic [W-1:0] en1);
    vec_t v;
    v.rv = rv; v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1; v.a0 = a0; v.a1 = a1;
    v.eb0 = eb0; v.eb1 = eb1; v.en0 = en0; v.en1 = en1;
    return v;
  endfunction

  initial begin
    int nb, cyc;
    logic r, stalled12;

    vecs[0] = mk(2'b01, 5'd0, 32'hDEADBEEF, 5'd0, 32'h0,  5'd0, 5'd0, 32'h0,  32'h0,  32'h0,  32'h0);
    vecs[1] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd0, 5'd0, 32'h0,  32'h0,  32'h0,  32'h0);
    vecs[2] = mk(2'b11, 5'd5, 32'h11,       5'd5, 32'h22, 5'd5, 5'd5, 32'h22, 32'h22, 32'h0,  32'h0);
    vecs[3] = mk(2'b01, 5'd6, 32'h33,       5'd6, 32'h44, 5'd5, 5'd6, 32'h22, 32'h33, 32'h22, 32'h0);
    vecs[4] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd6, 5'd5, 32'h33, 32'h22, 32'h33, 32'h22);
    vecs[5] = mk(2'b10, 5'd0, 32'h0,        5'd7, 32'hA,  5'd5, 5'd7, 32'h22, 32'hA,  32'h22, 32'h0);
    vecs[6] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd7, 5'd7, 32'hA,  32'hA,  32'hA,  32'hA);
    vecs[7] = mk(2'b11, 5'd7, 32'hB,        5'd8, 32'hC,  5'd7, 5'd8, 32'hB,  32'hC,  32'hA,  32'h0);
    vecs[8] = mk(2'b11, 5'd9, 32'h1,        5'd0, 32'hFF, 5'd9, 5'd0, 32'h1,  32'h0,  32'h0,  32'h0);
    vecs[9] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd9, 5'd8, 32'h1,  32'hC,  32'h1,  32'hC);

    // Reset block
    rst = 1'b1; dump_req = 1'b0; dump_ready = 1'b0; rd_addr = '0;
    retire_clear();
    #1;
    check("rst_dump_valid", 32'(dv_b), 32'h0);
    check("rst_dump_busy",  32'(db_b), 32'h0);
    check("rst_dump_idx",   32'(di_b), 32'h0);
    check("rst_dump_data",  dd_b, 32'h0);
    check("rst_dump_last",  32'(dl_n), 32'h0);
    check("rst_rd0",        rd_data_b[0], 32'h0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    tick();

    // Read/write/bypass vectors
    foreach (vecs[i]) begin
      retire_valid       = vecs[i].rv;
      retire_reg[0]      = vecs[i].r0;
      retire_reg[1]      = vecs[i].r1;
      retire_reg_data[0] = vecs[i].d0;
      retire_reg_data[1] = vecs[i].d1;
      rd_addr[0]         = vecs[i].a0;
      rd_addr[1]         = vecs[i].a1;
      #1;
      check($sformatf("vec%0d_byp_rd0", i), rd_data_b[0], vecs[i].eb0);
      check($sformatf("vec%0d_byp_rd1", i), rd_data_b[1], vecs[i].eb1);
      check($sformatf("vec%0d_nb_rd0", i),  rd_data_n[0], vecs[i].en0);
      check($sformatf("vec%0d_nb_rd1", i),  rd_data_n[1], vecs[i].en1);
      tick();
    end
    retire_clear();

    // Asynchronous reset mid-cycle clears the file immediately
    rd_addr[0] = 5'd5; rd_addr[1] = 5'd7;
    #1;
    check("pre_rst_rd0", rd_data_b[0], 32'h22);
    #2 rst = 1'b1;
    #1;
    check("async_rst_byp_rd0", rd_data_b[0], 32'h0);
    check("async_rst_nb_rd1",  rd_data_n[1], 32'h0);
    #2 rst = 1'b0;
    tick();

    // Backpressure with random ready and concurrent retires
    preload();
    exp_q.delete();
    for (int i = 0; i < NR; i++) exp_q.push_back(W'(i * 256));
    exp_q[10] = 32'h55;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    nb = 0; cyc = 0; stalled12 = 1'b0;
    while (nb < NR && cyc < 400) begin
      cyc++;
      check("bp_valid",   32'(dv_b), 32'h1);
      check("bp_idx",     32'(di_b), 32'(nb));
      check("bp_data",    dd_b, exp_q[0]);
      check("bp_data_nb", dd_n, exp_q[0]);
      check("bp_last",    32'(dl_b), 32'(nb == NR - 1));
      r = 1'($urandom_range(0, 1));
      if (nb == 9) r = 1'b1;
      if (nb == 12 && !stalled12) begin
        r = 1'b0;
        stalled12 = 1'b1;
        retire_valid = 2'b10; retire_reg[1] = 5'd12; retire_reg_data[1] = 32'h77;
      end
      if (nb == 9) begin
        retire_valid = 2'b01; retire_reg[0] = 5'd10; retire_reg_data[0] = 32'h55;
      end
      dump_ready = r;
      tick();
      retire_clear();
      if (r) begin
        nb++;
        void'(exp_q.pop_front());
      end
    end
    if (nb < NR) check("bp_timeout_beats", 32'(nb), 32'(NR));
    dump_ready = 1'b0;
    check("bp_end_valid", 32'(dv_b), 32'h0);
    check("bp_end_busy",  32'(db_n), 32'h0);
    rd_addr[0] = 5'd10; rd_addr[1] = 5'd12;
    #1;
    check("bp_reg10", rd_data_n[0], 32'h55);
    check("bp_reg12", rd_data_n[1], 32'h77);

    // Full dump with ready high; dump_req held to check ignore and restart
    preload();
    exp_q.delete();
    for (int i = 0; i < NR; i++) exp_q.push_back(W'(i * 256));
    dump_req = 1'b1; dump_ready = 1'b1;
    tick();
    for (int b = 0; b < NR; b++) begin
      check("full_valid", 32'(dv_b), 32'h1);
      check("full_busy",  32'(db_b), 32'h1);
      check("full_idx",   32'(di_b), 32'(b));
      check("full_data",  dd_b, exp_q[0]);
      check("full_last",  32'(dl_b), 32'(b == NR - 1));
      void'(exp_q.pop_front());
      tick();
    end
    check("full_idle_valid", 32'(dv_b), 32'h0);
    check("full_idle_busy",  32'(db_b), 32'h0);
    check("full_idle_last",  32'(dl_b), 32'h0);
    tick();
    check("restart_valid", 32'(dv_b), 32'h1);
    check("restart_idx",   32'(di_b), 32'h0);
    dump_req = 1'b0;

    // Reset mid-dump at beat 12, then a fresh dump of the cleared file
    for (int b = 0; b < 12; b++) tick();
    check("mid_idx_12", 32'(di_b), 32'd12);
    check("mid_data_12", dd_b, 32'hC00);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(dv_b), 32'h0);
    check("mid_rst_busy",  32'(db_b), 32'h0);
    check("mid_rst_idx",   32'(di_b), 32'h0);
    check("mid_rst_data",  dd_b, 32'h0);
    check("mid_rst_nb_valid", 32'(dv_n), 32'h0);
    #2 rst = 1'b0;
    tick();
    check("post_rst_idle", 32'(dv_b), 32'h0);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int b = 0; b < NR; b++) begin
      check("redump_valid", 32'(dv_b), 32'h1);
      check("redump_idx",   32'(di_b), 32'(b));
      check("redump_data",  dd_b, 32'h0);
      tick();
    end
    check("redump_end_valid", 32'(dv_b), 32'h0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
